// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, bit timing, line idle level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    NEXT      = 2'd3
  } arb_state_t;

  // 115200 baud from the 50 MHz system clock.
  localparam int unsigned c_CYCLES_PER_BIT = 50000000 / 115200;

  localparam logic c_LINE_IDLE = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requesting index at or after i_PTR,
// wrapping modulo c_NUM_REQ.
//   i_REQ   request vector
//   i_PTR   starting index (must be < c_NUM_REQ)
//   o_GRANT one-hot of the picked index, zero when nothing requests
//   o_IDX   picked index
//   o_VALID some request was found
module rr_priority_pick
  import uart_pkg::*;
#(
  parameter int unsigned c_NUM_REQ = 4,
  parameter int unsigned c_IDX_W   = (c_NUM_REQ > 1) ? $clog2(c_NUM_REQ) : 1
) (
  input  logic [c_NUM_REQ-1:0] i_REQ,
  input  logic [c_IDX_W-1:0]   i_PTR,
  output logic [c_NUM_REQ-1:0] o_GRANT,
  output logic [c_IDX_W-1:0]   o_IDX,
  output logic                 o_VALID
);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_REQ - 1);

  always_comb begin
    logic [c_IDX_W-1:0] cand;
    o_GRANT = '0;
    o_IDX   = '0;
    o_VALID = 1'b0;
    cand    = i_PTR;
    for (int unsigned k = 0; k < c_NUM_REQ; k++) begin
      if (!o_VALID && i_REQ[cand]) begin
        o_VALID       = 1'b1;
        o_IDX         = cand;
        o_GRANT[cand] = 1'b1;
      end
      // Explicit wrap so non-power-of-two requester counts work.
      cand = (cand == c_LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX between c_NUM_REQ packet sources, round-robin per packet.
//   i_CLK, i_RESET_n        clock, synchronous active-low reset
//   i_REQ/i_REQ_DATA/i_REQ_LAST  per-requester byte available, byte lanes, last flag
//   o_REQ_ACK               one-cycle pulse to the owner when its byte is taken
//   o_GRANT                 one-hot current owner, zero when idle
//   o_TX_DV/o_TX_BYTE       start pulse and held byte to UART_TX
//   i_TX_ACTIVE/i_TX_DONE   UART_TX status
//   o_BUSY                  not idle
//   o_TIMEOUT               pulse when an owner's grant is revoked for stalling
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned c_NUM_REQ        = 4,
  parameter int unsigned c_TIMEOUT_CYCLES = 4096
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET_n,
  input  logic [c_NUM_REQ-1:0]   i_REQ,
  input  logic [8*c_NUM_REQ-1:0] i_REQ_DATA,
  input  logic [c_NUM_REQ-1:0]   i_REQ_LAST,
  output logic [c_NUM_REQ-1:0]   o_REQ_ACK,
  output logic [c_NUM_REQ-1:0]   o_GRANT,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_BYTE,
  input  logic                   i_TX_ACTIVE,
  input  logic                   i_TX_DONE,
  output logic                   o_BUSY,
  output logic                   o_TIMEOUT
);

  localparam int unsigned c_IDX_W = (c_NUM_REQ > 1) ? $clog2(c_NUM_REQ) : 1;
  localparam int unsigned c_CNT_W = (c_TIMEOUT_CYCLES > 1) ? $clog2(c_TIMEOUT_CYCLES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(c_TIMEOUT_CYCLES - 1);

  arb_state_t             state, state_n;
  logic [c_IDX_W-1:0]     owner, owner_n;
  logic [c_IDX_W-1:0]     rr_ptr, rr_ptr_n;
  logic [c_NUM_REQ-1:0]   grant, grant_n;
  logic [7:0]             tx_byte, tx_byte_n;
  logic                   last_flag, last_flag_n;
  logic [c_CNT_W-1:0]     tout_cnt, tout_cnt_n;
  logic                   timeout, timeout_n;

  logic [7:0]             lane [c_NUM_REQ];
  logic [c_NUM_REQ-1:0]   pick_grant;
  logic [c_IDX_W-1:0]     pick_idx;
  logic                   pick_valid;
  logic [c_IDX_W-1:0]     owner_inc;

  for (genvar g = 0; g < c_NUM_REQ; g++) begin : g_lane
    assign lane[g] = i_REQ_DATA[8*g +: 8];
  end

  assign owner_inc = (owner == c_LAST_IDX) ? '0 : owner + 1'b1;

  rr_priority_pick #(
    .c_NUM_REQ (c_NUM_REQ),
    .c_IDX_W   (c_IDX_W)
  ) u_pick (
    .i_REQ   (i_REQ),
    .i_PTR   (rr_ptr),
    .o_GRANT (pick_grant),
    .o_IDX   (pick_idx),
    .o_VALID (pick_valid)
  );

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      tx_byte   <= '0;
      last_flag <= 1'b0;
      tout_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      grant     <= grant_n;
      tx_byte   <= tx_byte_n;
      last_flag <= last_flag_n;
      tout_cnt  <= tout_cnt_n;
      timeout   <= timeout_n;
    end
  end

  // Byte and last flag are captured on the edge entering ISSUE so o_TX_BYTE
  // is already valid alongside the o_TX_DV pulse.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    grant_n     = grant;
    tx_byte_n   = tx_byte;
    last_flag_n = last_flag;
    tout_cnt_n  = '0;
    timeout_n   = 1'b0;

    o_TX_DV   = (state == ISSUE);
    o_REQ_ACK = (state == ISSUE) ? grant : '0;
    o_BUSY    = (state != IDLE);
    o_GRANT   = grant;
    o_TX_BYTE = tx_byte;
    o_TIMEOUT = timeout;

    case (state)
      IDLE: begin
        if (pick_valid && !i_TX_ACTIVE) begin
          state_n     = ISSUE;
          owner_n     = pick_idx;
          grant_n     = pick_grant;
          tx_byte_n   = lane[pick_idx];
          last_flag_n = i_REQ_LAST[pick_idx];
        end
      end
      ISSUE: begin
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_TX_DONE) begin
          if (last_flag) begin
            state_n  = IDLE;
            grant_n  = '0;
            rr_ptr_n = owner_inc;
          end else begin
            state_n = NEXT;
          end
        end
      end
      NEXT: begin
        if (i_REQ[owner]) begin
          // A pending byte is not a stall, even while an external TX blocks issue.
          if (!i_TX_ACTIVE) begin
            state_n     = ISSUE;
            tx_byte_n   = lane[owner];
            last_flag_n = i_REQ_LAST[owner];
          end
        end else if (tout_cnt == c_CNT_MAX) begin
          state_n   = IDLE;
          grant_n   = '0;
          rr_ptr_n  = owner_inc;
          timeout_n = 1'b1;
        end else begin
          tout_cnt_n = tout_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
